// File: rtl/mem_rq_seq.sv
// MBox memory request sequencer: accepts a quadword read/write request, starts the bus, then tracks acknowledge and data words.
// Optional watchdog abort enabled by defining MEM_RQ_SEQ_TIMEOUT_EN.
module mem_rq_seq (
  input  logic       clk,
  input  logic       RESET_L,
  input  logic       RQ_VALID,
  input  logic       RQ_RD,
  input  logic       RQ_WR,
  input  logic [3:0] RQ_WORDS,
  output logic       RQ_READY,
  input  logic       SBUS_ACKN,
  input  logic       SBUS_DATA_VALID,
  input  logic       NXM_ACKN,
  output logic       MEM_START_A,
  output logic       MEM_START_B,
  output logic       RQ_HOLD_FF,
  output logic       ACKN_PULSE,
  output logic       CORE_RD_IN_PROG,
  output logic       A_CHANGE_COMING_IN,
  output logic [1:0] WD_SEL,
  output logic       DONE,
  output logic       DONE_NXM,
  output logic       TIMEOUT_ERR
);

  localparam int unsigned MASK_W  = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned PHASE_W = 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT_ACK, S_DATA, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                rd_q, rd_d, wr_q, wr_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic                ready_q, ready_d, start_a_q, start_a_d, start_b_q, start_b_d;
  logic                hold_q, hold_d, ackn_q, ackn_d, core_rd_q, core_rd_d;
  logic                a_change_q, a_change_d, done_q, done_d, done_nxm_q, done_nxm_d;
  logic [SEL_W-1:0]    wd_sel_q, wd_sel_d;

`ifdef MEM_RQ_SEQ_TIMEOUT_EN
  localparam int unsigned WDOG_W = 8;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(254);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout_q, timeout_d;
`endif

  // Index of the lowest set bit; the next word the memory will return
  function automatic logic [SEL_W-1:0] lowest_bit(input logic [MASK_W-1:0] m);
    lowest_bit = '0;
    for (int i = MASK_W - 1; i >= 0; i--)
      if (m[i]) lowest_bit = SEL_W'(i);
  endfunction

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    mask_d     = mask_q;
    ackn_d     = 1'b0;
    done_nxm_d = 1'b0;
`ifdef MEM_RQ_SEQ_TIMEOUT_EN
    wdog_d     = wdog_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // Gate on the registered ready so nothing is taken while RQ_READY reads 0
        if (ready_q && RQ_VALID) begin
          rd_d   = RQ_RD;
          wr_d   = RQ_WR;
          mask_d = RQ_WORDS;
          state_d = ((RQ_RD || RQ_WR) && (RQ_WORDS != '0)) ? S_START : S_DONE;
        end
      end
      S_START: begin
        state_d = S_WAIT_ACK;
`ifdef MEM_RQ_SEQ_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      S_WAIT_ACK: begin
        if (SBUS_ACKN) begin
          ackn_d  = 1'b1;
          state_d = rd_q ? S_DATA : S_DONE;
        end else if (NXM_ACKN) begin
          done_nxm_d = 1'b1;
          state_d    = S_DONE;
        end else begin
`ifdef MEM_RQ_SEQ_TIMEOUT_EN
          if (wdog_q == WDOG_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            wdog_d = wdog_q + WDOG_W'(1);
          end
`endif
        end
      end
      S_DATA: begin
        if (SBUS_DATA_VALID) begin
          mask_d = mask_q & ~MASK_W'(4'b0001 << wd_sel_q);
          if (mask_d == '0) state_d = S_DONE;
`ifdef MEM_RQ_SEQ_TIMEOUT_EN
          wdog_d = '0;
        end else if (wdog_q == WDOG_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered images of the state being entered
    ready_d   = (state_d == S_IDLE);
    hold_d    = (state_d != S_IDLE);
    start_a_d = ((state_d == S_START) || (state_d == S_WAIT_ACK)) && rd_d;
    start_b_d = ((state_d == S_START) || (state_d == S_WAIT_ACK)) && wr_d;
    core_rd_d = (state_d == S_DATA);
    done_d    = (state_d == S_DONE);
    wd_sel_d  = (state_d == S_DATA) ? lowest_bit(mask_d) : '0;

    if ((state_d == S_START) || (state_d == S_IDLE)) phase_d = '0;
    else if (hold_q)                                 phase_d = phase_q + PHASE_W'(1);
    else                                             phase_d = phase_q;
    a_change_d = (phase_d == PHASE_W'(3));
  end

  always_ff @(posedge clk) begin
    if (!RESET_L) begin
      state_q    <= S_IDLE;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      mask_q     <= '0;
      phase_q    <= '0;
      ready_q    <= 1'b0;
      start_a_q  <= 1'b0;
      start_b_q  <= 1'b0;
      hold_q     <= 1'b0;
      ackn_q     <= 1'b0;
      core_rd_q  <= 1'b0;
      a_change_q <= 1'b0;
      wd_sel_q   <= '0;
      done_q     <= 1'b0;
      done_nxm_q <= 1'b0;
`ifdef MEM_RQ_SEQ_TIMEOUT_EN
      wdog_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      mask_q     <= mask_d;
      phase_q    <= phase_d;
      ready_q    <= ready_d;
      start_a_q  <= start_a_d;
      start_b_q  <= start_b_d;
      hold_q     <= hold_d;
      ackn_q     <= ackn_d;
      core_rd_q  <= core_rd_d;
      a_change_q <= a_change_d;
      wd_sel_q   <= wd_sel_d;
      done_q     <= done_d;
      done_nxm_q <= done_nxm_d;
`ifdef MEM_RQ_SEQ_TIMEOUT_EN
      wdog_q     <= wdog_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign RQ_READY           = ready_q;
  assign MEM_START_A        = start_a_q;
  assign MEM_START_B        = start_b_q;
  assign RQ_HOLD_FF         = hold_q;
  assign ACKN_PULSE         = ackn_q;
  assign CORE_RD_IN_PROG    = core_rd_q;
  assign A_CHANGE_COMING_IN = a_change_q;
  assign WD_SEL             = wd_sel_q;
  assign DONE               = done_q;
  assign DONE_NXM           = done_nxm_q;
`ifdef MEM_RQ_SEQ_TIMEOUT_EN
  assign TIMEOUT_ERR        = timeout_q;
`else
  assign TIMEOUT_ERR        = 1'b0;
`endif

endmodule

// File: doc/mem_rq_seq.md
MEM_RQ_SEQ -- requirements
Module: mem_rq_seq

Interface
REQ-001 clk  in  1  MBox clock, all state on rising edge.
REQ-002 RESET_L  in  1  synchronous reset, active low.
REQ-003 RQ_VALID  in  1  requester offers a memory cycle.
REQ-004 RQ_RD / RQ_WR  in  1 each  read / write request; both set = read-pause-write.
REQ-005 RQ_WORDS  in  4  word mask for quadword, bit 0 = word 0.
REQ-006 RQ_READY  out  1  sequencer idle, accepts request this cycle.
REQ-007 SBUS_ACKN / SBUS_DATA_VALID  in  1 each  memory acknowledge / read word valid.
REQ-008 NXM_ACKN  in  1  NXM logic synthesized acknowledge (no memory responded).
REQ-009 MEM_START_A / MEM_START_B  out  1 each  read-start / write-start to SBUS and NXM logic.
REQ-010 RQ_HOLD_FF  out  1  cycle in progress, holds error-address capture.
REQ-011 ACKN_PULSE  out  1  one-cycle acknowledge strobe.
REQ-012 CORE_RD_IN_PROG  out  1  read data phase active.
REQ-013 A_CHANGE_COMING_IN  out  1  phase tick feeding NXM timer.
REQ-014 WD_SEL  out  2  index of word currently expected.
REQ-015 DONE / DONE_NXM  out  1 each  cycle-complete pulse / completion was NXM.
REQ-016 TIMEOUT_ERR  out  1  watchdog abort pulse (see Configuration).

Function
REQ-017 States IDLE, START, WAIT_ACK, DATA, DONE; all outputs registered.
REQ-018 IDLE: RQ_READY=1; RQ_VALID & (RQ_RD|RQ_WR) captures RD, WR, mask; next state START.
REQ-019 Accept with RQ_WORDS=0 or neither RD nor WR: no bus start, DONE pulses next cycle, back to IDLE.
REQ-020 RQ_READY=0 in every state except IDLE; RQ_VALID then ignored.
REQ-021 START (1 cycle) -> WAIT_ACK; MEM_START_A=RD, MEM_START_B=WR from START entry until the acknowledge cycle inclusive.
REQ-022 RQ_HOLD_FF=1 in START, WAIT_ACK, DATA, DONE.
REQ-023 2-bit phase counter cleared on START entry, increments each cycle RQ_HOLD_FF=1; A_CHANGE_COMING_IN=1 when phase==3.
REQ-024 WAIT_ACK: SBUS_ACKN -> ACKN_PULSE one cycle; next DATA if RD else DONE.
REQ-025 WAIT_ACK: NXM_ACKN without SBUS_ACKN -> DONE with DONE_NXM=1, no ACKN_PULSE; SBUS_ACKN wins if both.
REQ-026 SBUS_DATA_VALID outside DATA ignored.
REQ-027 DATA: CORE_RD_IN_PROG=1; WD_SEL = lowest uncompleted set mask bit; each SBUS_DATA_VALID retires it.
REQ-028 Retiring the last set bit -> DONE; word count equals popcount of mask (1..4).
REQ-029 DONE lasts one cycle, DONE=1, then IDLE; WD_SEL returns to 0.
REQ-030 Read-pause-write: DATA completes reads, then ACKN_PULSE not repeated; MEM_START_B stays low after acknowledge.

Reset
REQ-031 RESET_L=0 at a clock edge forces IDLE from any state, mid-cycle included.
REQ-032 During reset all outputs 0, including RQ_READY; WD_SEL=0, phase=0.
REQ-033 First cycle after release: RQ_READY=1, no residual pulses.

Configuration
REQ-034 Macro MEM_RQ_SEQ_TIMEOUT_EN: defined -> 8-bit watchdog cleared on WAIT_ACK entry and on each data word, counts in WAIT_ACK/DATA; reaching 255 -> TIMEOUT_ERR one-cycle pulse, DONE pulse, IDLE.
REQ-035 Macro undefined -> no watchdog, TIMEOUT_ERR tied 0, WAIT_ACK/DATA wait indefinitely.

Verification
REQ-036 Read mask 4'b1111, ACKN at cycle 3 after accept, DATA_VALID x4 -> ACKN_PULSE once, WD_SEL 0,1,2,3, DONE 1 cycle after 4th word.
REQ-037 Write mask 4'b0001 -> MEM_START_B high START..ACKN, no CORE_RD_IN_PROG, DONE next cycle after ACKN.
REQ-038 Read mask 4'b1010, NXM_ACKN in WAIT_ACK -> DONE=1, DONE_NXM=1, ACKN_PULSE never set.
REQ-039 SBUS_ACKN and NXM_ACKN same cycle -> ACKN_PULSE=1, DONE_NXM=0; mask 4'b0100 gives WD_SEL=2, one word.
REQ-040 RESET_L low during DATA of 4-word read -> all outputs 0 next edge, RQ_READY=1 first cycle after release.
REQ-041 With MEM_RQ_SEQ_TIMEOUT_EN, no ACKN for 255 cycles -> TIMEOUT_ERR and DONE pulse together; without the macro, still in WAIT_ACK at cycle 300.
